// File: rtl/adc_serial_if.sv
// Serial ADC front-end: power sequencing, wake-up delay and 16-bit SPI-style read.
// Optional ADC_AVERAGE_EN: four frames per request, result is the truncated mean.
module adc_serial_if #(
  parameter int CLK_DIV      = 2,
  parameter int WAKEUP_TICKS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adc_enable,
  input  logic        adc_read,
  input  logic        adc_sdo,
  output logic        adc_pwr_en,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_ready,
  output logic        adc_conversion_complete,
  output logic [15:0] adc_value
);

  localparam int CNT_MAX = (WAKEUP_TICKS > CLK_DIV) ? WAKEUP_TICKS : CLK_DIV;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKEUP_TICKS - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_WAKEUP   = 3'd1,
    S_READY    = 3'd2,
    S_CS_SETUP = 3'd3,
    S_SHIFT    = 3'd4,
    S_GAP      = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    half_q, half_d;
  logic          pend_q, pend_d;
  logic          read_q;
  logic [15:0]   shift_q, shift_d;
  logic          sclk_q, sclk_d;
  logic          pwr_en_q, pwr_en_d;
  logic          cs_n_q, cs_n_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic [15:0]   value_q, value_d;
  logic          edge_s;
`ifdef ADC_AVERAGE_EN
  logic [1:0]    frame_q, frame_d;
  logic [17:0]   sum_q, sum_d;
  logic [17:0]   sum_next_s;
`endif

  assign edge_s = adc_read & ~read_q;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    pend_d  = pend_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    value_d = value_q;
`ifdef ADC_AVERAGE_EN
    frame_d    = frame_q;
    sum_d      = sum_q;
    sum_next_s = sum_q + {2'b00, shift_q};
`endif
    case (state_q)
      S_OFF: begin
        if (adc_enable) begin
          state_d = S_WAKEUP;
          cnt_d   = '0;
          pend_d  = edge_s;
        end else begin
          pend_d = 1'b0;
        end
      end
      S_WAKEUP: begin
        if (edge_s) pend_d = 1'b1;
        else        pend_d = pend_q;
        if (cnt_q == WAKE_LAST) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_READY: begin
        if (edge_s || pend_q) begin
          state_d = S_CS_SETUP;
          cnt_d   = '0;
          pend_d  = 1'b0;
`ifdef ADC_AVERAGE_EN
          frame_d = 2'd0;
          sum_d   = 18'd0;
`endif
        end else begin
          state_d = S_READY;
        end
      end
      S_CS_SETUP: begin
        // Leaving setup raises SCLK for the first time, so the MSB is captured here
        if (cnt_q == DIV_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          half_d  = 5'd0;
          sclk_d  = 1'b1;
          shift_d = {shift_q[14:0], adc_sdo};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (half_q == 5'd31) begin
`ifdef ADC_AVERAGE_EN
            if (frame_q == 2'd3) begin
              state_d = S_DONE;
              value_d = sum_next_s[17:2];
            end else begin
              state_d = S_GAP;
              sum_d   = sum_next_s;
              frame_d = frame_q + 2'd1;
            end
`else
            state_d = S_DONE;
            value_d = shift_q;
`endif
          end else begin
            half_d = half_q + 5'd1;
            sclk_d = ~sclk_q;
            if (!sclk_q) shift_d = {shift_q[14:0], adc_sdo};
            else         shift_d = shift_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_CS_SETUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_READY;
      end
      default: begin
        state_d = S_OFF;
      end
    endcase

    // Dropping enable aborts everything but keeps the last published result
    if (!adc_enable) begin
      state_d = S_OFF;
      pend_d  = 1'b0;
      value_d = value_q;
`ifdef ADC_AVERAGE_EN
      sum_d   = 18'd0;
`endif
    end else begin
      value_d = value_d;
    end

    if (state_d != S_SHIFT) sclk_d = 1'b0;
    else                    sclk_d = sclk_d;

    pwr_en_d = (state_d != S_OFF);
    cs_n_d   = !((state_d == S_CS_SETUP) || (state_d == S_SHIFT));
    ready_d  = (state_d == S_READY);
    done_d   = (state_d == S_DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      half_q   <= 5'd0;
      pend_q   <= 1'b0;
      read_q   <= 1'b0;
      shift_q  <= 16'd0;
      sclk_q   <= 1'b0;
      pwr_en_q <= 1'b0;
      cs_n_q   <= 1'b1;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      value_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      pend_q   <= pend_d;
      read_q   <= adc_read;
      shift_q  <= shift_d;
      sclk_q   <= sclk_d;
      pwr_en_q <= pwr_en_d;
      cs_n_q   <= cs_n_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      value_q  <= value_d;
    end
  end

`ifdef ADC_AVERAGE_EN
  // Frame index and running sum for the averaging sequence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= 2'd0;
      sum_q   <= 18'd0;
    end else begin
      frame_q <= frame_d;
      sum_q   <= sum_d;
    end
  end
`endif

  assign adc_pwr_en              = pwr_en_q;
  assign adc_cs_n                = cs_n_q;
  assign adc_sclk                = sclk_q;
  assign adc_ready               = ready_q;
  assign adc_conversion_complete = done_q;
  assign adc_value               = value_q;

endmodule
